// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared types, widths and error equation for the sensor alarm supervisor
package sensor_pkg;

  localparam int SENSOR_W = 4;

  typedef enum logic [1:0] {IDLE, PENDING, ALARM, CLEAR_WAIT} alarm_state_t;

  // Sensor 0 alone is fatal; sensor 1 is fatal only together with sensor 2 or 3.
  function automatic logic sensor_err(input logic [3:0] s);
    return s[0] | (s[1] & (s[3] | s[2]));
  endfunction

endpackage

// File: rtl/debounce_counter.sv
// rtl/debounce_counter.sv - debounce up-counter with clear and terminal-count flag
module debounce_counter #(
  parameter int DEBOUNCE = 4,
  parameter int W        = $clog2(DEBOUNCE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_enable,
  output logic rollover_flag
);

  localparam logic [W-1:0] LAST = W'(DEBOUNCE - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rollover_flag = (cnt_q == LAST);

endmodule

// File: rtl/sensor_alarm_ctrl.sv
// rtl/sensor_alarm_ctrl.sv - synchronizes and masks sensors, debounces the error, latches alarm until ack
module sensor_alarm_ctrl
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SENSOR_W-1:0] sensors,
  input  logic [SENSOR_W-1:0] mask,
  input  logic                ack,
  output logic                alarm,
  output logic                pending,
  output logic [SENSOR_W-1:0] fault_snap,
  output logic [CNT_W-1:0]    alarm_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SENSOR_W-1:0] s_meta_q;
  logic [SENSOR_W-1:0] s_sync_q;
  logic [SENSOR_W-1:0] s_m;
  logic                err;

  alarm_state_t        state_q, state_d;
  logic                alarm_q, pending_q;
  logic [SENSOR_W-1:0] snap_q;
  logic [CNT_W-1:0]    count_q;
  logic                rollover;
  logic                enter_alarm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta_q <= '0;
      s_sync_q <= '0;
    end else begin
      s_meta_q <= sensors;
      s_sync_q <= s_meta_q;
    end
  end

  assign s_m = s_sync_q & mask;
  assign err = sensor_err(s_m);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (err) begin
          state_d = (DEBOUNCE == 1) ? ALARM : PENDING;
        end
      end
      PENDING: begin
        if (!err) begin
          state_d = IDLE;
        end else if (rollover) begin
          state_d = ALARM;
        end
      end
      ALARM: begin
        if (ack) begin
          state_d = err ? CLEAR_WAIT : IDLE;
        end
      end
      CLEAR_WAIT: begin
        if (!err) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_alarm = (state_d == ALARM) && (state_q != ALARM);

  // The counter only runs while the next state is PENDING, so it reads 1 on the first pending cycle.
  debounce_counter #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .clear        (state_d != PENDING),
    .count_enable (state_d == PENDING),
    .rollover_flag(rollover)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      alarm_q   <= 1'b0;
      pending_q <= 1'b0;
      snap_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= (state_d == ALARM);
      pending_q <= (state_d == PENDING);
      if (enter_alarm) begin
        snap_q <= s_m;
        if (count_q != CNT_MAX) begin
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  assign alarm       = alarm_q;
  assign pending     = pending_q;
  assign fault_snap  = snap_q;
  assign alarm_count = count_q;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// tb/tb_sensor_alarm_ctrl.sv - directed bench for sensor_alarm_ctrl
module tb_sensor_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sensors, mask;
  logic       ack;
  logic       alarm, pending;
  logic [3:0] fault_snap;
  logic [7:0] alarm_count;

  logic [3:0] sensors2, mask2;
  logic       ack2;
  logic       alarm2, pending2;
  logic [3:0] fault_snap2;
  logic [1:0] alarm_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sensor_alarm_ctrl #(.DEBOUNCE(4), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .sensors    (sensors),
    .mask       (mask),
    .ack        (ack),
    .alarm      (alarm),
    .pending    (pending),
    .fault_snap (fault_snap),
    .alarm_count(alarm_count)
  );

  sensor_alarm_ctrl #(.DEBOUNCE(1), .CNT_W(2)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .sensors    (sensors2),
    .mask       (mask2),
    .ack        (ack2),
    .alarm      (alarm2),
    .pending    (pending2),
    .fault_snap (fault_snap2),
    .alarm_count(alarm_count2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] pat;
  logic [1:0] exp_cnt;

  initial begin
    rst = 1'b1; sensors = 4'h0; mask = 4'hF; ack = 1'b0;
    sensors2 = 4'h0; mask2 = 4'hF; ack2 = 1'b0;
    step(2);
    check("rst_alarm", {31'b0, alarm}, 0);
    check("rst_pending", {31'b0, pending}, 0);
    check("rst_snap", {28'b0, fault_snap}, 0);
    check("rst_count", {24'b0, alarm_count}, 0);
    rst = 1'b0;

    // Glitch of three sampled cycles must not alarm
    sensors = 4'b0110;
    step(3);
    check("glitch_pending_e2", {31'b0, pending}, 1);
    sensors = 4'b0000;
    step(2);
    check("glitch_pending_e4", {31'b0, pending}, 1);
    check("glitch_alarm_e4", {31'b0, alarm}, 0);
    step(1);
    check("glitch_pending_e5", {31'b0, pending}, 0);
    check("glitch_alarm_e5", {31'b0, alarm}, 0);
    step(3);
    check("glitch_alarm_late", {31'b0, alarm}, 0);
    check("glitch_count", {24'b0, alarm_count}, 0);

    // Basic debounce with sensor 0
    sensors = 4'b0001;
    step(2);
    check("t1_pending_e1", {31'b0, pending}, 0);
    step(1);
    check("t1_pending_e2", {31'b0, pending}, 1);
    step(2);
    check("t1_alarm_e4", {31'b0, alarm}, 0);
    step(1);
    check("t1_alarm_e5", {31'b0, alarm}, 1);
    check("t1_pending_e5", {31'b0, pending}, 0);
    check("t1_snap", {28'b0, fault_snap}, 4'b0001);
    check("t1_count", {24'b0, alarm_count}, 1);

    // Ack while error persists goes to CLEAR_WAIT, no re-capture or re-alarm
    sensors = 4'b1010;
    step(3);
    check("t3_alarm_hold", {31'b0, alarm}, 1);
    check("t3_snap_hold", {28'b0, fault_snap}, 4'b0001);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t3_alarm_after_ack", {31'b0, alarm}, 0);
    step(6);
    check("t3_no_realarm", {31'b0, alarm}, 0);
    check("t3_no_pending", {31'b0, pending}, 0);
    check("t3_count_hold", {24'b0, alarm_count}, 1);
    sensors = 4'b0000;
    step(3);
    sensors = 4'b1010;
    step(3);
    check("t3_pending_again", {31'b0, pending}, 1);
    step(3);
    check("t3_alarm2", {31'b0, alarm}, 1);
    check("t3_snap2", {28'b0, fault_snap}, 4'b1010);
    check("t3_count2", {24'b0, alarm_count}, 2);

    // Alarm holds without ack; ack with error gone returns to IDLE
    sensors = 4'b0000;
    step(4);
    check("t3b_alarm_latched", {31'b0, alarm}, 1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t3b_alarm_off", {31'b0, alarm}, 0);
    step(1);
    check("t3b_pending_off", {31'b0, pending}, 0);

    // Masked sensor 0 is ignored, sensor 1 with sensor 3 still alarms
    mask = 4'b1110;
    sensors = 4'b0001;
    step(8);
    check("t4_masked_alarm", {31'b0, alarm}, 0);
    check("t4_masked_pending", {31'b0, pending}, 0);
    sensors = 4'b1011;
    step(6);
    check("t4_alarm", {31'b0, alarm}, 1);
    check("t4_snap", {28'b0, fault_snap}, 4'b1010);
    check("t4_count", {24'b0, alarm_count}, 3);

    // Asynchronous reset in ALARM, then a full debounce again
    rst = 1'b1;
    #1;
    check("t5_rst_alarm", {31'b0, alarm}, 0);
    check("t5_rst_pending", {31'b0, pending}, 0);
    check("t5_rst_snap", {28'b0, fault_snap}, 0);
    check("t5_rst_count", {24'b0, alarm_count}, 0);
    #1;
    rst = 1'b0;
    step(3);
    check("t5_pending_e2", {31'b0, pending}, 1);
    step(2);
    check("t5_alarm_e4", {31'b0, alarm}, 0);
    step(1);
    check("t5_alarm_e5", {31'b0, alarm}, 1);
    check("t5_count", {24'b0, alarm_count}, 1);

    // DEBOUNCE=1, CNT_W=2 saturation: counts 1,2,3,3,3 while snapshot keeps updating
    for (int i = 0; i < 5; i++) begin
      pat = (i % 2 == 0) ? 4'b0001 : 4'b1110;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      sensors2 = pat;
      step(2);
      check("sat_alarm_e1", {31'b0, alarm2}, 0);
      step(1);
      check("sat_alarm_e2", {31'b0, alarm2}, 1);
      check("sat_pending", {31'b0, pending2}, 0);
      check("sat_snap", {28'b0, fault_snap2}, {28'b0, pat});
      check("sat_count", {30'b0, alarm_count2}, {30'b0, exp_cnt});
      sensors2 = 4'b0000;
      step(2);
      ack2 = 1'b1;
      step(1);
      ack2 = 1'b0;
      check("sat_alarm_ack", {31'b0, alarm2}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
